load_store_unit: RTL and testbench

Initiator side of the data-memory interface: accepts byte-addressed load/store requests from the core's execute stage and drives the word-indexed `memory_read`/`memory_write`/`address`/`write_data`/`read_data` port of the data memory. It handles RV32I widths (LB/LH/LW/LBU/LHU/SB/SH/SW):

- extracts and extends sub-word load data;
- implements sub-word stores as read-modify-write;
- reports out-of-range and illegal accesses.

It sits between the execute stage and the data memory.

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/lsu_align.sv | 50 +++++
 rtl/load_store_unit.sv | 154 +++++++++++++++
 tb/tb_load_store_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I funct3 width/sign codes for loads and stores
//   - FSM state encoding
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational lane handling for the load/store unit.
// Ports:
//   rd_word    in  32  word read from memory (load path)
//   old_word   in  32  previously read word (store merge path)
//   offset     in  2   byte address bits [1:0]
//   funct3     in  3   RV32I width/sign code
//   wdata      in  32  right-aligned store data
//   load_data  out 32  selected lane, sign- or zero-extended
//   store_word out 32  old_word with the addressed lane replaced
// Halfword lane is chosen by offset[1] alone; offset[0] is ignored for
// halfwords and offset[1:0] for words.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] old_word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [31:0] shifted;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    shifted = rd_word >> {offset, 3'b000};
    lane_b  = shifted[7:0];
    lane_h  = offset[1] ? rd_word[31:16] : rd_word[15:0];
    case (funct3)
      F3_LB:   load_data = {{24{lane_b[7]}}, lane_b};
      F3_LBU:  load_data = {24'h0, lane_b};
      F3_LH:   load_data = {{16{lane_h[15]}}, lane_h};
      F3_LHU:  load_data = {16'h0, lane_h};
      default: load_data = rd_word;
    endcase
  end

  always_comb begin
    store_word = old_word;
    case (funct3[1:0])
      2'b00:   store_word[{offset, 3'b000} +: 8]       = wdata[7:0];
      2'b01:   store_word[{offset[1], 4'b0000} +: 16]  = wdata[15:0];
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the data-memory port.
// Accepts byte-addressed RV32I loads/stores, drives a word-indexed memory
// with combinational read data, does read-modify-write for SB/SH.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   req_valid/req_ready              request handshake
//   req_write, req_funct3            store flag, width/sign code
//   req_address, req_wdata           byte address, right-aligned store data
//   resp_valid/resp_ready            response handshake
//   resp_rdata, resp_error           load result (0 for stores/errors), fault
//   memory_read, memory_write        memory enables (never both high)
//   address, write_data, read_data   word index, write word, read word
// Build option: define LSU_MISALIGN_TRAP_EN to fault misaligned halfword
// and word accesses; otherwise low address bits are ignored for them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEMORY_SIZE = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        memory_read,
  output logic        memory_write,
  output logic [31:0] address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEMORY_SIZE);

  lsu_state_e  state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] old_q, old_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;
  logic        acc_err;
  logic [31:0] load_data, merged;

  lsu_align u_align (
    .rd_word    (read_data),
    .old_word   (old_q),
    .offset     (addr_q[1:0]),
    .funct3     (funct3_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (merged)
  );

  // Fault classification of the incoming request, evaluated at accept.
  always_comb begin
    acc_err = (req_address >= MEM_LIMIT);
    if (req_write) begin
      if (!(req_funct3 inside {F3_SB, F3_SH, F3_SW})) acc_err = 1'b1;
    end else begin
      if (req_funct3 inside {3'b011, 3'b110, 3'b111}) acc_err = 1'b1;
    end
`ifdef LSU_MISALIGN_TRAP_EN
    if (req_funct3[1:0] == 2'b01 && req_address[0])          acc_err = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_address[1:0] != 2'b00) acc_err = 1'b1;
`endif
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    old_d    = old_q;
    rdata_d  = rdata_q;
    error_d  = error_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_address;
          wdata_d  = req_wdata;
          rdata_d  = 32'h0;
          error_d  = acc_err;
          if (acc_err)                          state_d = RESP;
          else if (req_write && req_funct3 == F3_SW) state_d = WRITE;
          else                                  state_d = READ;
        end
      end
      READ: begin
        // Sub-word stores keep the old word for the merge in WRITE.
        if (write_q) begin
          old_d   = read_data;
          state_d = WRITE;
        end else begin
          rdata_d = load_data;
          state_d = RESP;
        end
      end
      WRITE: state_d = RESP;
      RESP: begin
        if (resp_ready) begin
          rdata_d = 32'h0;
          error_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      funct3_q <= 3'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      old_q    <= 32'h0;
      rdata_q  <= 32'h0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      old_q    <= old_d;
      rdata_q  <= rdata_d;
      error_q  <= error_d;
    end
  end

  // Memory-side outputs decode the current state only, so a WRITE cycle
  // keeps its enable even when reset lands on its closing edge.
  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == RESP);
  assign resp_rdata   = rdata_q;
  assign resp_error   = error_q;
  assign memory_read  = (state_q == READ);
  assign memory_write = (state_q == WRITE);
  assign address      = (memory_read || memory_write) ? {2'b00, addr_q[31:2]} : 32'h0;
  assign write_data   = memory_write ? merged : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, resp_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_address, req_wdata;
  logic        req_ready, resp_valid, resp_error, memory_read, memory_write;
  logic [31:0] resp_rdata, address, write_data, read_data;

  load_store_unit #(.MEMORY_SIZE(4096)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_address(req_address), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .memory_read(memory_read), .memory_write(memory_write),
    .address(address), .write_data(write_data), .read_data(read_data)
  );

  always #5 clk = ~clk;

  // Word-indexed data memory, combinational read.
  logic [31:0] mem [0:1023];
  assign read_data = (address < 32'd1024) ? mem[address[9:0]] : 32'h0;
  always @(posedge clk) if (memory_write && address < 32'd1024) mem[address[9:0]] <= write_data;

  int rd_cnt = 0, wr_cnt = 0;
  always @(negedge clk) begin
    if (memory_read)  rd_cnt++;
    if (memory_write) wr_cnt++;
  end

  int n_chk = 0, n_fail = 0;
  int rd0, wr0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge (the accept edge N); returns in cycle N+1.
  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_address = a; req_wdata = wd;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    chk({tag, "_rvalid"}, {31'h0, resp_valid}, 32'h0);
    chk({tag, "_en"}, {30'h0, memory_read, memory_write}, 32'h0);
    chk({tag, "_addr"}, address, 32'h0);
    chk({tag, "_wdat"}, write_data, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[1] = 32'h80FF_1234;
    mem[4] = 32'h1122_3344;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
    req_address = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
    tick(); tick();
    chk_idle("rst");
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", {31'h0, resp_error}, 32'h0);
    reset = 1'b0;
    tick();

    // LB at 0x7: READ of word 1, response at N+2.
    rd0 = rd_cnt;
    issue(1'b0, F3_LB, 32'h7, 32'h0);
    chk("lb_rd", {31'h0, memory_read}, 32'h1);
    chk("lb_addr", address, 32'h1);
    chk("lb_ready", {31'h0, req_ready}, 32'h0);
    chk("lb_early", {31'h0, resp_valid}, 32'h0);
    tick();
    chk("lb_rvalid", {31'h0, resp_valid}, 32'h1);
    chk("lb_data", resp_rdata, 32'hFFFF_FF80);
    chk("lb_err", {31'h0, resp_error}, 32'h0);
    chk("lb_rdcnt", rd_cnt - rd0, 32'h1);
    tick();
    chk("lb_back", {31'h0, req_ready}, 32'h1);

    issue(1'b0, F3_LBU, 32'h7, 32'h0);
    tick();
    chk("lbu_data", resp_rdata, 32'h0000_0080);
    tick();

    issue(1'b0, F3_LH, 32'h6, 32'h0);
    tick();
    chk("lh_data", resp_rdata, 32'hFFFF_80FF);
    tick();
    issue(1'b0, F3_LHU, 32'h6, 32'h0);
    tick();
    chk("lhu_data", resp_rdata, 32'h0000_80FF);
    tick();

    // SH 0xABCD at 0x12: READ, WRITE, response at N+3.
    wr0 = wr_cnt;
    issue(1'b1, F3_SH, 32'h12, 32'h0000_ABCD);
    chk("sh_rd", {31'h0, memory_read}, 32'h1);
    chk("sh_raddr", address, 32'h4);
    tick();
    chk("sh_wr", {30'h0, memory_read, memory_write}, 32'h1);
    chk("sh_wdata", write_data, 32'hABCD_3344);
    chk("sh_early", {31'h0, resp_valid}, 32'h0);
    tick();
    chk("sh_rvalid", {31'h0, resp_valid}, 32'h1);
    chk("sh_err", {31'h0, resp_error}, 32'h0);
    chk("sh_rdata", resp_rdata, 32'h0);
    chk("sh_mem", mem[4], 32'hABCD_3344);
    chk("sh_wrcnt", wr_cnt - wr0, 32'h1);
    tick();

    // SB 0x5A into the top byte of word 4.
    issue(1'b1, F3_SB, 32'h13, 32'hFFFF_FF5A);
    tick();
    chk("sb_wdata", write_data, 32'h5ACD_3344);
    tick();
    chk("sb_mem", mem[4], 32'h5ACD_3344);
    tick();

    // SW to the last word, then out-of-range LW.
    wr0 = wr_cnt;
    issue(1'b1, F3_SW, 32'h0FFC, 32'hDEAD_BEEF);
    chk("sw_wr", {30'h0, memory_read, memory_write}, 32'h1);
    chk("sw_addr", address, 32'd1023);
    chk("sw_wdata", write_data, 32'hDEAD_BEEF);
    tick();
    chk("sw_rvalid", {31'h0, resp_valid}, 32'h1);
    chk("sw_mem", mem[1023], 32'hDEAD_BEEF);
    chk("sw_wrcnt", wr_cnt - wr0, 32'h1);
    tick();

    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(1'b0, F3_LW, 32'h1000, 32'h0);
    chk("oor_rvalid", {31'h0, resp_valid}, 32'h1);
    chk("oor_err", {31'h0, resp_error}, 32'h1);
    chk("oor_rdata", resp_rdata, 32'h0);
    chk("oor_en", rd_cnt - rd0 + wr_cnt - wr0, 32'h0);
    tick();

    // Illegal funct3: load 011 and store 100.
    issue(1'b0, 3'b011, 32'h0, 32'h0);
    chk("ill_ld", {30'h0, resp_valid, resp_error}, 32'h3);
    tick();
    issue(1'b1, 3'b100, 32'h0, 32'h0);
    chk("ill_st", {30'h0, resp_valid, resp_error}, 32'h3);
    tick();
    chk("ill_en", rd_cnt - rd0 + wr_cnt - wr0, 32'h0);

    // LW at 0x6.
    issue(1'b0, F3_LW, 32'h6, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_err", {30'h0, resp_valid, resp_error}, 32'h3);
    chk("mis_rdata", resp_rdata, 32'h0);
`else
    chk("mis_addr", address, 32'h1);
    tick();
    chk("mis_err", {30'h0, resp_valid, resp_error}, 32'h2);
    chk("mis_rdata", resp_rdata, 32'h80FF_1234);
`endif
    tick();

    // Backpressure: response held while a new request is ignored.
    resp_ready = 1'b0;
    rd0 = rd_cnt;
    issue(1'b0, F3_LH, 32'h4, 32'h0);
    tick();
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = F3_LW; req_address = 32'h10;
    for (int i = 0; i < 3; i++) begin
      chk("bp_rvalid", {31'h0, resp_valid}, 32'h1);
      chk("bp_rdata", resp_rdata, 32'h0000_1234);
      chk("bp_ready", {31'h0, req_ready}, 32'h0);
      tick();
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    tick();
    chk_idle("bp_done");
    tick();
    chk("bp_ignored", {31'h0, resp_valid}, 32'h0);
    chk("bp_rdcnt", rd_cnt - rd0, 32'h1);

    // Reset during the READ of an SB.
    wr0 = wr_cnt;
    issue(1'b1, F3_SB, 32'h10, 32'h0000_0055);
    chk("rr_rd", {31'h0, memory_read}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle("rr");
    chk("rr_rdata", resp_rdata, 32'h0);
    chk("rr_err", {31'h0, resp_error}, 32'h0);
    tick(); tick();
    chk("rr_nowr", wr_cnt - wr0, 32'h0);
    chk("rr_mem", mem[4], 32'h5ACD_3344);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
